// File: rtl/restador_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package restador_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

endpackage

// File: rtl/restador1bit.sv
// 1-bit full-subtractor cell: dif = a - b - b_in, with borrow out.
// Gate-level structure mirrors the companion full-adder cell.
module restador1bit (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic dif,
    output logic b_out
);

    wire a_x_b;
    wire a_n;
    wire a_x_b_n;
    wire brw_gen;
    wire brw_prop;

    xor g_x0 (a_x_b, a, b);
    xor g_x1 (dif, a_x_b, b_in);

    // Borrow is generated by 0-1, or propagated when a and b are equal.
    not g_n0 (a_n, a);
    and g_a0 (brw_gen, a_n, b);
    not g_n1 (a_x_b_n, a_x_b);
    and g_a1 (brw_prop, a_x_b_n, b_in);
    or  g_o0 (b_out, brw_gen, brw_prop);

endmodule

// File: rtl/restador_serial.sv
// Bit-serial two's-complement subtractor: one bit per clock, LSB first,
// with start/busy/done handshake and borrow/overflow/zero status flags.
//
// state   | meaning
// IDLE    | waiting for start; operands loaded on accept
// SHIFT   | one difference bit per cycle, WIDTH cycles
// DONE    | single-cycle done pulse; start here begins the next operation
module restador_serial
    import restador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             zero
);

    state_e           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             borrow_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;
    logic             ovf_q;
    logic             zero_q;

    logic             bit_dif;
    logic             bit_bn;
    logic [WIDTH-1:0] res_d;

    restador1bit u_cell (
        .a     (sa_q[0]),
        .b     (sb_q[0]),
        .b_in  (borrow_q),
        .dif   (bit_dif),
        .b_out (bit_bn)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 is the LSB.
    assign res_d = (res_q >> 1) | {bit_dif, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sa_q     <= sa_q >> 1;
                    sb_q     <= sb_q >> 1;
                    res_q    <= res_d;
                    borrow_q <= bit_bn;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        // borrow_q is the borrow into the MSB, bit_bn the borrow out of it.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_d;
                        b_out_q <= bit_bn;
                        ovf_q   <= borrow_q ^ bit_bn;
                        zero_q  <= (res_d == '0);
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q     <= a;
                        sb_q     <= b;
                        res_q    <= '0;
                        cnt_q    <= '0;
                        borrow_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SHIFT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_restador_serial.sv
// Bench for restador_serial: directed WIDTH=8 cases plus a randomized
// WIDTH=16 regression against an arithmetic reference model.
module tb_restador_serial;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    logic       st8;
    logic [7:0] a8, b8, diff8;
    logic       busy8, done8, bo8, ovf8, z8;

    logic        st16;
    logic [15:0] a16, b16, diff16;
    logic        busy16, done16, bo16, ovf16, z16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    restador_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .b_out(bo8), .ovf(ovf8), .zero(z8)
    );

    restador_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .b_out(bo16), .ovf(ovf16), .zero(z16)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the operand values.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  output longint d, output bit bo, output bit ov, output bit z);
        longint mask;
        bit sa, sb, sd;
        mask = (longint'(1) << w) - 1;
        d  = (ua - ub) & mask;
        bo = (ua < ub);
        sa = ((ua >> (w-1)) & 1) != 0;
        sb = ((ub >> (w-1)) & 1) != 0;
        sd = ((d  >> (w-1)) & 1) != 0;
        ov = (sa != sb) && (sd != sa);
        z  = (d == 0);
    endfunction

    task automatic go8(input logic [7:0] ta, input logic [7:0] tb_, output int k);
        @(negedge clk);
        a8  = ta;
        b8  = tb_;
        st8 = 1'b1;
        k   = cyc + 1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
    endtask

    task automatic wait_done8(input string tag, output int dc);
        bit seen;
        bit early;
        seen  = 1'b0;
        early = 1'b0;
        dc    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) begin
                seen = 1'b1;
                dc   = cyc + 1;
            end else if (!busy8) begin
                early = 1'b1;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_busy_held"}, early, 0);
    endtask

    task automatic res8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input int k, input int dc);
        longint d;
        bit bo, ov, z;
        model(8, longint'(ta), longint'(tb_), d, bo, ov, z);
        chk({tag, "_diff"}, longint'(diff8), d);
        chk({tag, "_b_out"}, longint'(bo8), longint'(bo));
        chk({tag, "_ovf"}, longint'(ovf8), longint'(ov));
        chk({tag, "_zero"}, longint'(z8), longint'(z));
        chk({tag, "_latency"}, dc - k, 9);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] dir_a [5] = '{8'h05, 8'h03, 8'h55, 8'h80, 8'h7F};
    logic [7:0] dir_b [5] = '{8'h03, 8'h05, 8'h55, 8'h01, 8'hFF};

    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          qk [$];
    bit          qbb [$];

    initial begin
        int k, k2, dc, dc2, n_done_seen;
        int ops_issued, ops_done, last_dc;

        rst_n = 1'b0;
        st8 = 1'b0;  a8 = '0;  b8 = '0;
        st16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset8_outputs", longint'({busy8, done8, diff8, bo8, ovf8, z8}), 0);
        chk("reset16_outputs", longint'({busy16, done16, diff16, bo16, ovf16, z16}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            go8(dir_a[i], dir_b[i], k);
            wait_done8($sformatf("dir%0d", i), dc);
            res8($sformatf("dir%0d", i), dir_a[i], dir_b[i], k, dc);
        end

        // Start and operand changes during SHIFT must be ignored.
        go8(8'hA0, 8'h21, k);
        repeat (3) @(negedge clk);
        chk("hold_diff_in_shift", longint'(diff8), 64'h80);
        chk("busy_in_shift", longint'(busy8), 1);
        st8 = 1'b1;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        @(negedge clk);
        st8 = 1'b0;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        wait_done8("ignore", dc);
        res8("ignore", 8'hA0, 8'h21, k, dc);

        // Back-to-back: start during the DONE cycle.
        a8  = 8'h3C;
        b8  = 8'h5A;
        st8 = 1'b1;
        k2  = cyc + 1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        wait_done8("b2b", dc2);
        res8("b2b", 8'h3C, 8'h5A, k2, dc2);
        chk("b2b_spacing", dc2 - dc, 9);

        // Reset sampled at the edge ending the 4th SHIFT cycle.
        go8(8'hC3, 8'h11, k);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", longint'({busy8, done8, diff8, bo8, ovf8, z8}), 0);
        rst_n = 1'b1;
        n_done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) n_done_seen++;
        end
        chk("midreset_no_done", n_done_seen, 0);
        go8(8'h10, 8'h01, k);
        wait_done8("after_reset", dc);
        res8("after_reset", 8'h10, 8'h01, k, dc);

        // WIDTH=16 randomized regression.
        ops_issued = 0;
        ops_done   = 0;
        last_dc    = 0;
        for (int t = 0; t < 40000 && ops_done < 1000; t++) begin
            @(negedge clk);
            if (done16) begin
                if (qa.size() == 0) begin
                    chk("r16_unexpected_done", 1, 0);
                end else begin
                    longint d;
                    bit bo, ov, z, bb;
                    logic [15:0] ea, eb;
                    int ek;
                    ea = qa.pop_front();
                    eb = qb.pop_front();
                    ek = qk.pop_front();
                    bb = qbb.pop_front();
                    model(16, longint'(ea), longint'(eb), d, bo, ov, z);
                    chk("r16_diff", longint'(diff16), d);
                    chk("r16_b_out", longint'(bo16), longint'(bo));
                    chk("r16_ovf", longint'(ovf16), longint'(ov));
                    chk("r16_zero", longint'(z16), longint'(z));
                    chk("r16_latency", cyc + 1 - ek, 17);
                    if (bb) chk("r16_spacing", cyc + 1 - last_dc, 17);
                    last_dc = cyc + 1;
                    ops_done++;
                end
            end
            if (!busy16 && ops_issued < 1000 && $urandom_range(3) != 0) begin
                case ($urandom_range(7))
                    0: begin a16 = 16'($urandom); b16 = a16; end
                    1: begin a16 = 16'h8000; b16 = 16'($urandom); end
                    2: begin a16 = 16'h7FFF; b16 = 16'($urandom); end
                    default: begin a16 = 16'($urandom); b16 = 16'($urandom); end
                endcase
                st16 = 1'b1;
                qa.push_back(a16);
                qb.push_back(b16);
                qk.push_back(cyc + 1);
                qbb.push_back(done16);
                ops_issued++;
            end else if (busy16) begin
                st16 = 1'($urandom_range(1));
                a16  = 16'($urandom);
                b16  = 16'($urandom);
            end else begin
                st16 = 1'b0;
            end
        end
        st16 = 1'b0;
        chk("r16_ops_completed", ops_done, 1000);
        chk("r16_queue_empty", qa.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/restador_serial.md
Name: restador_serial

Overview:
Bit-serial N-bit two's-complement subtractor for the MicroUAZ datapath. It is the inverse operation of the team's 1-bit full-adder cell.
- Processes one bit per clock, LSB first, through a single 1-bit full-subtractor cell and a registered borrow.
- Uses a start/busy/done handshake.
- Produces the difference plus unsigned-borrow, signed-overflow and zero flags for the ALU status register.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

Ports:
clk      input   1       system clock, rising edge
rst_n    input   1       synchronous active-low reset
start    input   1       request; sampled only when busy=0
a        input   WIDTH   minuend, captured on accepted start
b        input   WIDTH   subtrahend, captured on accepted start
busy     output  1       high while bits are being processed
done     output  1       one-cycle pulse: result and flags valid
diff     output  WIDTH   a - b (mod 2^WIDTH)
b_out    output  1       final borrow: 1 when unsigned a < b
ovf      output  1       signed overflow of a - b
zero     output  1       diff == 0

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE; busy=0, done=0, diff=0, b_out=0, ovf=0, zero=0
  - internal shift registers, counter and borrow = 0
- Reset has priority over everything. Reset mid-operation aborts with no done pulse.
- States: IDLE, SHIFT, DONE.
  - IDLE: busy=0. On start=1: load sa<=a, sb<=b, borrow<=0, cnt<=0, and move to SHIFT.
  - SHIFT: busy=1. Each cycle:
    - ai=sa[0], bi=sb[0]
    - d = ai^bi^borrow
    - bn = (~ai&bi) | (~(ai^bi)&borrow)
    - shift sa and sb right by 1
    - shift d into the MSB of the result register (shift right)
    - borrow<=bn, cnt<=cnt+1
    - On the cycle with cnt==WIDTH-1, capture the borrow entering the MSB (borrow before update) as bmsb, then move to DONE.
  - DONE, for exactly one cycle:
    - done=1, busy=0
    - diff=result register, b_out=borrow, ovf=bmsb^borrow, zero=(result==0)
    - Next state is IDLE, or SHIFT if start=1 in this cycle (back-to-back accepted; operands loaded the same cycle).
- Latency: start accepted at edge k; done high in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- diff, b_out, ovf and zero are registered and hold their last value until the next DONE or a reset. They are not updated during SHIFT.
- start while busy=1 is ignored, with no queuing. a and b may change freely after acceptance.
- start held high continuously restarts from every DONE cycle.
- Width rules:
  - diff is truncated mod 2^WIDTH.
  - b_out is unsigned borrow: a<b gives 1.
  - ovf is set iff the sign of a differs from the sign of b and the sign of diff differs from the sign of a.
- The counter does not wrap during a valid operation; counter values >= WIDTH are unreachable.

Decomposition:
- Shared package restador_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default DEF_WIDTH=8
- Natural sub-module: restador1bit, a combinational full-subtractor cell.
  - Inputs: a, b, b_in. Outputs: dif, b_out.
  - Built from xor/and/or gate primitives, mirroring the team's adder cell.
- restador_serial instantiates one restador1bit and contains only the FSM, counter, shift registers and flag logic.

Test Plan:
- WIDTH=8: a=0x05, b=0x03, start pulse → done exactly 9 cycles after accept; diff=0x02, b_out=0, ovf=0, zero=0.
- a=0x03, b=0x05 → diff=0xFE, b_out=1, ovf=0, zero=0. Then a=0x55, b=0x55 → diff=0x00, b_out=0, zero=1.
- a=0x80, b=0x01 → diff=0x7F, b_out=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, b_out=1, ovf=1.
- Start pulsed and a/b changed during SHIFT → ignored; result reflects the original operands; busy never drops early. start=1 on the DONE cycle → new op begins, second done 9 cycles later.
- rst_n=0 for 1 cycle at the 4th SHIFT cycle → next cycle all outputs 0, state IDLE, no done pulse. A subsequent op (0x10-0x01) → diff=0x0F.
- WIDTH=16 regression: 1000 random operand pairs → diff, b_out, ovf and zero match the reference model; done spacing = 17 cycles.
